fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the decoder.
- Holds the PC and issues word reads to instruction memory over a valid/ready request and valid response interface.
- Buffers returned words in a small FIFO and presents {instr, instr_pc} to decode with a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing the buffer and discarding any stale in-flight response.

---
 rtl/fetch_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Keeps the PC and issues one word read at a time to instruction memory.
// Buffers returned words in a small FIFO and presents {instr, instr_pc} to decode.
// A redirect flushes the buffer and discards any stale in-flight response.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When defined, the instr_misaligned
// output is added and fetch halts after an unaligned redirect target. When undefined,
// the low two bits of redirect_pc are forced to zero.
module fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                  instr_misaligned
`endif
);

    localparam int unsigned           PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned           CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]      DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);

    // IDLE: buffer has no room; REQ: request presented; WAIT: one request outstanding;
    // DROP: outstanding response belongs to a flushed path.
    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDrop
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  req_valid_q, req_valid_d;

    logic [DATA_WIDTH-1:0] buf_data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] buf_pc_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      count_after_pop;

    logic                  instr_valid_q, instr_valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;

    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] redir_target;
    logic                  redir_bad;
    logic                  halted;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;

    assign redir_target     = redirect_pc;
    assign redir_bad        = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign halted           = misaligned_q;
    assign instr_misaligned = misaligned_q;

    // Trap flag: every redirect rewrites it with the alignment of its target
    always_comb begin
        misaligned_d = misaligned_q;
        if (redirect_valid) begin
            misaligned_d = redir_bad;
        end
    end

    // Trap flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`else
    logic [1:0] unused_redirect_lo;

    assign unused_redirect_lo = redirect_pc[1:0];
    assign redir_target       = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign redir_bad          = 1'b0;
    assign halted             = 1'b0;
`endif

    // A redirect kills both the push of a same-cycle response and any pop.
    assign push            = (state_q == StWait) && imem_resp_valid && !redirect_valid;
    assign pop             = instr_valid_q && instr_ready && !redirect_valid;
    assign count_after_pop = count_q - CNT_W'(pop);

    // Buffer pointers/occupancy and the registered head presented to decode
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        if (redirect_valid) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            instr_valid_d = 1'b0;
            if (redir_bad) begin
                instr_pc_d = redirect_pc;
            end
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d       = count_after_pop + CNT_W'(push);
            instr_valid_d = (count_d != '0);
            if (count_after_pop == '0) begin
                // Buffer drains this cycle: a pushed word bypasses straight to the head
                if (push) begin
                    instr_d    = imem_resp_data;
                    instr_pc_d = req_addr_q;
                end
            end else begin
                instr_d    = buf_data_q[rd_ptr_d];
                instr_pc_d = buf_pc_q[rd_ptr_d];
            end
        end
    end

    // Fetch FSM next state, PC update and request-address capture
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        unique case (state_q)
            StIdle: begin
                // Nothing is reserved in IDLE, so occupancy alone decides
                if (!halted && (count_q < DEPTH_CNT)) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (imem_req_ready) begin
                    pc_d       = pc_q + PC_STEP;
                    req_addr_d = pc_q;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (imem_resp_valid) begin
                    state_d = (count_d < DEPTH_CNT) ? StReq : StIdle;
                end
            end
            StDrop: begin
                if (imem_resp_valid) begin
                    state_d = halted ? StIdle : StReq;
                end
            end
            default: state_d = StIdle;
        endcase

        if (redirect_valid) begin
            pc_d = redir_target;
            unique case (state_q)
                // A response landing with the redirect retires the outstanding request
                StWait:  state_d = imem_resp_valid ? StReq : StDrop;
                // Handshake completes this cycle, so its response must be dropped
                StReq:   state_d = imem_req_ready ? StDrop : StReq;
                // Leave DROP only once the stale response has actually arrived
                StDrop:  state_d = imem_resp_valid ? StReq : StDrop;
                default: state_d = StReq;
            endcase
            if (redir_bad && (state_d == StReq)) begin
                state_d = StIdle;
            end
        end

        req_valid_d = (state_d == StReq);
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            req_valid_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            req_valid_q   <= req_valid_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    // Buffer storage; contents are qualified by count_q so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data_q[wr_ptr_q] <= imem_resp_data;
            buf_pc_q[wr_ptr_q]   <= req_addr_q;
        end
    end

    // imem_addr tracks the PC, which stays put while a request waits for ready
    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr          = instr_q;
    assign instr_pc       = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests for fetch_unit with a one-cycle-latency memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        instr_misaligned;
`endif

    int errors = 0;
    int checks = 0;

    // Memory model state
    logic        mem_stall;
    logic        mem_pending;
    logic [31:0] mem_paddr;
    logic        mem_acc;
    logic [31:0] mem_a;

    fetch_unit #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .instr_misaligned(instr_misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory: sample the handshake at the edge, answer during the following cycle
    always @(posedge clk) begin
        mem_acc = imem_req_valid && imem_req_ready;
        mem_a   = imem_addr;
        #1;
        if (!rst_n) begin
            mem_pending     = 1'b0;
            imem_resp_valid = 1'b0;
        end else begin
            if (mem_acc) begin
                mem_pending = 1'b1;
                mem_paddr   = mem_a;
            end
            if (mem_pending && !mem_stall) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = word_of(mem_paddr);
                mem_pending     = 1'b0;
            end else begin
                imem_resp_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_stall      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL reset_req_valid got=%0b exp=0", imem_req_valid);
        end
        checks++;
        if (imem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_addr got=%h exp=00000000", imem_addr);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL reset_instr_valid got=%0b exp=0", instr_valid);
        end
        checks++;
        if (instr !== 32'h0) begin
            errors++; $display("FAIL reset_instr got=%h exp=00000000", instr);
        end
        checks++;
        if (instr_pc !== 32'h0) begin
            errors++; $display("FAIL reset_instr_pc got=%h exp=00000000", instr_pc);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] req_addrs [3];
        logic [31:0] pop_pcs   [3];
        logic [31:0] pop_data  [3];
        int nreq;
        int npop;
        int first;
        for (int i = 0; i < 3; i++) begin
            req_addrs[i] = 32'hFFFF_FFFF;
            pop_pcs[i]   = 32'hFFFF_FFFF;
            pop_data[i]  = 32'hFFFF_FFFF;
        end
        nreq  = 0;
        npop  = 0;
        first = -1;
        instr_ready = 1'b1;
        do_reset();
        for (int cyc = 1; cyc <= 20; cyc++) begin
            tick();
            if (imem_req_valid && nreq < 3) begin
                req_addrs[nreq] = imem_addr;
                nreq++;
            end
            if (instr_valid && first < 0) first = cyc;
            if (instr_valid && npop < 3) begin
                pop_pcs[npop]  = instr_pc;
                pop_data[npop] = instr;
                npop++;
            end
        end
        checks++;
        if (first !== 3) begin
            errors++; $display("FAIL first_valid_latency got=%0d exp=3", first);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_addrs[i] !== 32'(4 * i)) begin
                errors++; $display("FAIL fetch_req_addr[%0d] got=%h exp=%h", i, req_addrs[i], 4 * i);
            end
            checks++;
            if (pop_pcs[i] !== 32'(4 * i)) begin
                errors++; $display("FAIL fetch_instr_pc[%0d] got=%h exp=%h", i, pop_pcs[i], 4 * i);
            end
            checks++;
            if (pop_data[i] !== word_of(32'(4 * i))) begin
                errors++;
                $display("FAIL fetch_instr[%0d] got=%h exp=%h", i, pop_data[i], word_of(32'(4 * i)));
            end
        end
    endtask

    task automatic test_backpressure();
        int nreq;
        int got;
        nreq = 0;
        instr_ready = 1'b0;
        do_reset();
        for (int cyc = 1; cyc <= 12; cyc++) begin
            tick();
            if (imem_req_valid) nreq++;
        end
        checks++;
        if (nreq !== 2) begin
            errors++; $display("FAIL bp_request_count got=%0d exp=2", nreq);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== word_of(32'h0)) begin
            errors++;
            $display("FAIL bp_head got=v%0b pc=%h d=%h exp=v1 pc=00000000 d=%h",
                     instr_valid, instr_pc, instr, word_of(32'h0));
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_third_req got=%0b exp=0", imem_req_valid);
        end
        instr_ready = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin
            errors++; $display("FAIL bp_second_head got=v%0b pc=%h exp=v1 pc=00000004",
                               instr_valid, instr_pc);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drained got=%0b exp=0", instr_valid);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin
            errors++; $display("FAIL bp_resume_req got=v%0b a=%h exp=v1 a=00000008",
                               imem_req_valid, imem_addr);
        end
        got = 0;
        for (int i = 0; i < 8 && got == 0; i++) begin
            tick();
            if (instr_valid) got = 1;
        end
        checks++;
        if (got == 0 || instr_pc !== 32'h8) begin
            errors++; $display("FAIL bp_resume_instr got=v%0d pc=%h exp=v1 pc=00000008", got, instr_pc);
        end
    endtask

    task automatic test_redirect_wait();
        int found;
        int got;
        instr_ready = 1'b1;
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (imem_req_valid && imem_addr == 32'h8) found = 1;
        end
        checks++;
        if (found == 0) begin
            errors++; $display("FAIL rw_req8_seen got=0 exp=1");
        end
        mem_stall = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL rw_after_redirect got=v%0b rq%0b exp=v0 rq0",
                               instr_valid, imem_req_valid);
        end
        mem_stall = 1'b0;
        tick();
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL rw_drop_no_req got=%0b exp=0", imem_req_valid);
        end
        tick();
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL rw_new_req got=v%0b a=%h exp=v1 a=00000100",
                               imem_req_valid, imem_addr);
        end
        got = 0;
        for (int i = 0; i < 8 && got == 0; i++) begin
            tick();
            if (instr_valid) got = 1;
        end
        checks++;
        if (got == 0 || instr_pc !== 32'h100 || instr !== word_of(32'h100)) begin
            errors++; $display("FAIL rw_new_instr got=v%0d pc=%h d=%h exp=v1 pc=00000100 d=%h",
                               got, instr_pc, instr, word_of(32'h100));
        end
    endtask

    task automatic test_redirect_resp();
        int got;
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (instr_valid !== 1'b1 || imem_resp_valid !== 1'b1) begin
            errors++; $display("FAIL rr_setup got=v%0b resp%0b exp=v1 resp1",
                               instr_valid, imem_resp_valid);
        end
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++; $display("FAIL rr_flush got=%0b exp=0", instr_valid);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin
            errors++; $display("FAIL rr_new_req got=v%0b a=%h exp=v1 a=00000200",
                               imem_req_valid, imem_addr);
        end
        got = 0;
        for (int i = 0; i < 8 && got == 0; i++) begin
            tick();
            if (instr_valid) got = 1;
        end
        checks++;
        if (got == 0 || instr_pc !== 32'h200 || instr !== word_of(32'h200)) begin
            errors++; $display("FAIL rr_new_instr got=v%0d pc=%h d=%h exp=v1 pc=00000200 d=%h",
                               got, instr_pc, instr, word_of(32'h200));
        end
    endtask

    task automatic test_async_reset();
        int got;
        int rq;
        logic [31:0] first_addr;
        instr_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++; $display("FAIL ar_setup got=%0b exp=1", instr_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_addr !== 32'h0 ||
            instr !== 32'h0 || instr_pc !== 32'h0) begin
            errors++; $display("FAIL ar_async_clear got=v%0b rq%0b a=%h d=%h pc=%h exp=all zero",
                               instr_valid, imem_req_valid, imem_addr, instr, instr_pc);
        end
        tick();
        tick();
        rst_n       = 1'b1;
        instr_ready = 1'b1;
        rq         = 0;
        got        = 0;
        first_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 10 && got == 0; i++) begin
            tick();
            if (imem_req_valid && rq == 0) begin
                rq         = 1;
                first_addr = imem_addr;
            end
            if (instr_valid) got = 1;
        end
        checks++;
        if (first_addr !== 32'h0) begin
            errors++; $display("FAIL ar_restart_addr got=%h exp=00000000", first_addr);
        end
        checks++;
        if (got == 0 || instr_pc !== 32'h0 || instr !== word_of(32'h0)) begin
            errors++; $display("FAIL ar_restart_instr got=v%0d pc=%h d=%h exp=v1 pc=00000000 d=%h",
                               got, instr_pc, instr, word_of(32'h0));
        end
    endtask

`ifdef FETCH_MISALIGN_TRAP_EN
    task automatic test_misalign();
        int nreq;
        int got;
        instr_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (imem_req_valid) nreq++;
        end
        checks++;
        if (nreq !== 0) begin
            errors++; $display("FAIL ma_no_requests got=%0d exp=0", nreq);
        end
        checks++;
        if (instr_misaligned !== 1'b1 || instr_valid !== 1'b0 || instr_pc !== 32'h102) begin
            errors++; $display("FAIL ma_trap got=m%0b v%0b pc=%h exp=m1 v0 pc=00000102",
                               instr_misaligned, instr_valid, instr_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (instr_misaligned !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin
            errors++; $display("FAIL ma_clear got=m%0b rq%0b a=%h exp=m0 rq1 a=00000200",
                               instr_misaligned, imem_req_valid, imem_addr);
        end
        got = 0;
        for (int i = 0; i < 8 && got == 0; i++) begin
            tick();
            if (instr_valid) got = 1;
        end
        checks++;
        if (got == 0 || instr_pc !== 32'h200) begin
            errors++; $display("FAIL ma_resume got=v%0d pc=%h exp=v1 pc=00000200", got, instr_pc);
        end
    endtask
`else
    task automatic test_redirect_mask();
        int got;
        instr_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
            errors++; $display("FAIL mask_req got=v%0b a=%h exp=v1 a=00000100",
                               imem_req_valid, imem_addr);
        end
        got = 0;
        for (int i = 0; i < 8 && got == 0; i++) begin
            tick();
            if (instr_valid) got = 1;
        end
        checks++;
        if (got == 0 || instr_pc !== 32'h100 || instr !== word_of(32'h100)) begin
            errors++; $display("FAIL mask_instr got=v%0d pc=%h d=%h exp=v1 pc=00000100 d=%h",
                               got, instr_pc, instr, word_of(32'h100));
        end
    endtask
`endif

    initial begin
        rst_n           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        instr_ready     = 1'b0;
        mem_stall       = 1'b0;
        mem_pending     = 1'b0;
        mem_paddr       = 32'h0;
        test_reset();
        test_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_resp();
        test_async_reset();
`ifdef FETCH_MISALIGN_TRAP_EN
        test_misalign();
`else
        test_redirect_mask();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
